// File: rtl/rx_peak_finder_pkg.sv
// Shared constants, FSM state encoding and helpers for the rx peak finder.
//   CORR_W   : correlation result width (signed)
//   TS_W     : timestamp counter width
//   NUM_SEQ  : correlation sequences per result set
//   SEQ_ID_W : sequence index width
package rx_peak_finder_pkg;
  localparam int CORR_W   = 41;
  localparam int TS_W     = 32;
  localparam int NUM_SEQ  = 16;
  localparam int SEQ_ID_W = 4;

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_TRACK   = 2'd1,
    ST_HOLDOFF = 2'd2
  } state_e;

  // Two's-complement magnitude as an unsigned value of the same width;
  // the most negative input maps to 2^(CORR_W-1) without overflow.
  function automatic logic [CORR_W-1:0] abs_mag(input logic [CORR_W-1:0] x);
    return x[CORR_W-1] ? (~x + 1'b1) : x;
  endfunction
endpackage

// File: rtl/rx_peak_finder_if.sv
// Correlator-side bus of the peak finder.
//   erx_en/icorr_valid/icorr_seq/ithreshold : driven by the upstream side
//   odetect/oseq_id/opeak_mag/otimestamp/ooverrun : detection results
// master = upstream/driver, slave = rx_peak_finder.
interface rx_peak_finder_if;
  import rx_peak_finder_pkg::*;

  logic                             erx_en;
  logic                             icorr_valid;
  logic [NUM_SEQ-1:0][CORR_W-1:0]   icorr_seq;
  logic [CORR_W-1:0]                ithreshold;
  logic                             odetect;
  logic [SEQ_ID_W-1:0]              oseq_id;
  logic [CORR_W-1:0]                opeak_mag;
  logic [TS_W-1:0]                  otimestamp;
  logic                             ooverrun;

  modport master (
    output erx_en, icorr_valid, icorr_seq, ithreshold,
    input  odetect, oseq_id, opeak_mag, otimestamp, ooverrun
  );
  modport slave (
    input  erx_en, icorr_valid, icorr_seq, ithreshold,
    output odetect, oseq_id, opeak_mag, otimestamp, ooverrun
  );
endinterface

// File: rtl/rx_peak_finder_argmax.sv
// Serial argmax over one correlation set.
// Snapshots the 16 inputs and timestamp on valid_i, then evaluates one
// magnitude per clock in ascending index order and pulses done_o.
//   clk_i, rst_ni      : clock, async active-low reset
//   en_i               : low aborts the scan
//   valid_i, seq_i     : new set strobe and data
//   ts_i               : timestamp tag of the set
//   busy_o             : scan in progress (new valids are dropped)
//   done_o             : 1-cycle result pulse
//   best_mag_o/idx_o/ts_o : result, valid with done_o
module rx_peak_finder_argmax
  import rx_peak_finder_pkg::*;
(
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           en_i,
  input  logic                           valid_i,
  input  logic [NUM_SEQ-1:0][CORR_W-1:0] seq_i,
  input  logic [TS_W-1:0]                ts_i,
  output logic                           busy_o,
  output logic                           done_o,
  output logic [CORR_W-1:0]              best_mag_o,
  output logic [SEQ_ID_W-1:0]            best_idx_o,
  output logic [TS_W-1:0]                ts_o
);
  logic [NUM_SEQ-1:0][CORR_W-1:0] snap_q;
  logic [TS_W-1:0]                ts_q;
  logic [SEQ_ID_W:0]              cnt_q;   // MSB set = all indices visited
  logic                           busy_q, done_q;
  logic [CORR_W-1:0]              best_mag_q, cur_mag;
  logic [SEQ_ID_W-1:0]            best_idx_q;

  assign cur_mag = abs_mag(snap_q[cnt_q[SEQ_ID_W-1:0]]);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      snap_q     <= '0;
      ts_q       <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      best_mag_q <= '0;
      best_idx_q <= '0;
    end else if (!en_i) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      done_q <= 1'b0;
      if (!busy_q) begin
        if (valid_i) begin
          snap_q     <= seq_i;
          ts_q       <= ts_i;
          busy_q     <= 1'b1;
          cnt_q      <= '0;
          best_mag_q <= '0;
          best_idx_q <= '0;
        end
      end else if (!cnt_q[SEQ_ID_W]) begin
        // Strict '>' so a tie keeps the lower index.
        if (cur_mag > best_mag_q) begin
          best_mag_q <= cur_mag;
          best_idx_q <= cnt_q[SEQ_ID_W-1:0];
        end
        cnt_q <= cnt_q + 1'b1;
      end else begin
        done_q <= 1'b1;
        busy_q <= 1'b0;
      end
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign best_mag_o = best_mag_q;
  assign best_idx_o = best_idx_q;
  assign ts_o       = ts_q;
endmodule

// File: rtl/rx_peak_finder.sv
// Receive-chain peak finder: tags each correlation set with a timestamp,
// finds the strongest sequence per set, tracks the peak across a window
// and reports one detection followed by a hold-off.
//   crx_clk, rrx_rst_n : clock, async active-low reset
//   bus (slave)        : enable, correlation inputs, threshold, results
// Parameters: PEAK_WIN non-improving results close a peak (>=1);
//             HOLDOFF results ignored after a detection (0 = none).
module rx_peak_finder
  import rx_peak_finder_pkg::*;
#(
  parameter int PEAK_WIN = 16,
  parameter int HOLDOFF  = 256
) (
  input  logic             crx_clk,
  input  logic             rrx_rst_n,
  rx_peak_finder_if.slave  bus
);
  localparam int WIN_W  = $clog2(PEAK_WIN + 1);
  localparam int HOLD_W = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;

  logic                scan_busy, scan_done;
  logic [CORR_W-1:0]   scan_mag;
  logic [SEQ_ID_W-1:0] scan_idx;
  logic [TS_W-1:0]     scan_ts;

  state_e              state_q, state_d;
  logic [TS_W-1:0]     ts_q, ts_d;
  logic [WIN_W-1:0]    win_q, win_d, win_inc;
  logic [HOLD_W-1:0]   hold_q, hold_d, hold_inc;
  logic [CORR_W-1:0]   cand_mag_q, cand_mag_d;
  logic [SEQ_ID_W-1:0] cand_idx_q, cand_idx_d;
  logic [TS_W-1:0]     cand_ts_q, cand_ts_d;
  logic                det_q, det_d;
  logic [SEQ_ID_W-1:0] id_q, id_d;
  logic [CORR_W-1:0]   mag_q, mag_d;
  logic [TS_W-1:0]     tso_q, tso_d;
  logic                ovr_q, ovr_d;

  rx_peak_finder_argmax u_argmax (
    .clk_i      (crx_clk),
    .rst_ni     (rrx_rst_n),
    .en_i       (bus.erx_en),
    .valid_i    (bus.icorr_valid),
    .seq_i      (bus.icorr_seq),
    .ts_i       (ts_q),
    .busy_o     (scan_busy),
    .done_o     (scan_done),
    .best_mag_o (scan_mag),
    .best_idx_o (scan_idx),
    .ts_o       (scan_ts)
  );

  assign win_inc  = win_q + 1'b1;
  assign hold_inc = hold_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    win_d      = win_q;
    hold_d     = hold_q;
    cand_mag_d = cand_mag_q;
    cand_idx_d = cand_idx_q;
    cand_ts_d  = cand_ts_q;
    det_d      = 1'b0;
    id_d       = id_q;
    mag_d      = mag_q;
    tso_d      = tso_q;
    // Dropped sets still consume a timestamp.
    ovr_d      = ovr_q | (bus.icorr_valid & bus.erx_en & scan_busy);
    ts_d       = bus.icorr_valid ? ts_q + 1'b1 : ts_q;
    if (!bus.erx_en) begin
      state_d = ST_SEARCH;
      win_d   = '0;
      hold_d  = '0;
      ts_d    = '0;
    end else if (scan_done) begin
      case (state_q)
        ST_SEARCH: begin
          if (scan_mag > bus.ithreshold) begin
            cand_mag_d = scan_mag;
            cand_idx_d = scan_idx;
            cand_ts_d  = scan_ts;
            win_d      = '0;
            state_d    = ST_TRACK;
          end
        end
        ST_TRACK: begin
          if (scan_mag > cand_mag_q) begin
            cand_mag_d = scan_mag;
            cand_idx_d = scan_idx;
            cand_ts_d  = scan_ts;
            win_d      = '0;
          end else if (win_inc == WIN_W'(PEAK_WIN)) begin
            det_d   = 1'b1;
            id_d    = cand_idx_q;
            mag_d   = cand_mag_q;
            tso_d   = cand_ts_q;
            win_d   = '0;
            state_d = (HOLDOFF == 0) ? ST_SEARCH : ST_HOLDOFF;
          end else begin
            win_d = win_inc;
          end
        end
        ST_HOLDOFF: begin
          if (hold_inc == HOLD_W'(HOLDOFF)) begin
            hold_d  = '0;
            state_d = ST_SEARCH;
          end else begin
            hold_d = hold_inc;
          end
        end
        default: state_d = ST_SEARCH;
      endcase
    end
  end

  always_ff @(posedge crx_clk or negedge rrx_rst_n) begin
    if (!rrx_rst_n) begin
      state_q    <= ST_SEARCH;
      ts_q       <= '0;
      win_q      <= '0;
      hold_q     <= '0;
      cand_mag_q <= '0;
      cand_idx_q <= '0;
      cand_ts_q  <= '0;
      det_q      <= 1'b0;
      id_q       <= '0;
      mag_q      <= '0;
      tso_q      <= '0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ts_q       <= ts_d;
      win_q      <= win_d;
      hold_q     <= hold_d;
      cand_mag_q <= cand_mag_d;
      cand_idx_q <= cand_idx_d;
      cand_ts_q  <= cand_ts_d;
      det_q      <= det_d;
      id_q       <= id_d;
      mag_q      <= mag_d;
      tso_q      <= tso_d;
      ovr_q      <= ovr_d;
    end
  end

  assign bus.odetect    = det_q;
  assign bus.oseq_id    = id_q;
  assign bus.opeak_mag  = mag_q;
  assign bus.otimestamp = tso_q;
  assign bus.ooverrun   = ovr_q;
endmodule

// File: tb/tb_rx_peak_finder.sv
// Directed bench for rx_peak_finder (PEAK_WIN=4, HOLDOFF=8): a table of
// correlation sets with hand-computed expected outputs, plus hand-written
// sequences for overrun, enable flush in TRACK and reset mid-TRACK.
module tb_rx_peak_finder;
  import rx_peak_finder_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rx_peak_finder_if bus();

  rx_peak_finder #(.PEAK_WIN(4), .HOLDOFF(8)) dut (
    .crx_clk   (clk),
    .rrx_rst_n (rst_n),
    .bus       (bus)
  );

  int checks = 0;
  int errors = 0;
  int det_cnt = 0;

  always @(negedge clk) if (rst_n && bus.odetect) det_cnt++;

  typedef struct {
    bit     flush;
    longint thr;
    int     ia; longint va;
    int     ib; longint vb;
    int     ic; longint vc;
    bit     det;
    int     id;
    longint mag;
    longint ts;
  } vec_t;

  vec_t   tbl[$];
  bit     b_flush = 1'b0;
  bit     b_det = 1'b0;
  longint b_thr = 0;
  int     b_id = 0;
  longint b_mag = 0;
  longint b_ts = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic put(input int ia, input longint va, input int ib, input longint vb,
                     input int ic, input longint vc);
    vec_t v;
    v.flush = b_flush; b_flush = 1'b0;
    v.thr = b_thr;
    v.ia = ia; v.va = va; v.ib = ib; v.vb = vb; v.ic = ic; v.vc = vc;
    v.det = b_det; b_det = 1'b0;
    v.id = b_id; v.mag = b_mag; v.ts = b_ts;
    tbl.push_back(v);
  endtask

  task automatic putd(input int ia, input longint va, input int id, input longint mag,
                      input longint ts);
    b_det = 1'b1; b_id = id; b_mag = mag; b_ts = ts;
    put(ia, va, 0, 0, 0, 0);
  endtask

  task automatic zeros(input int n);
    for (int i = 0; i < n; i++) put(0, 0, 0, 0, 0, 0);
  endtask

  task automatic flush();
    @(negedge clk);
    bus.erx_en = 1'b0;
    repeat (3) @(negedge clk);
    bus.erx_en = 1'b1;
  endtask

  // Drives one set, then returns 1 time unit after the 18th edge following
  // the sampling edge, i.e. where a closing detection is visible.
  task automatic apply(input int ia, input longint va, input int ib, input longint vb,
                       input int ic, input longint vc, input longint thr);
    @(negedge clk);
    bus.ithreshold = CORR_W'(thr);
    bus.icorr_seq  = '0;
    if (va != 0) bus.icorr_seq[ia] = CORR_W'(va);
    if (vb != 0) bus.icorr_seq[ib] = CORR_W'(vb);
    if (vc != 0) bus.icorr_seq[ic] = CORR_W'(vc);
    bus.icorr_valid = 1'b1;
    @(posedge clk);
    #1 bus.icorr_valid = 1'b0;
    repeat (18) @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input bit det, input int id, input longint mag,
                         input longint ts);
    chk({tag, ".detect"}, 64'(bus.odetect), 64'(det));
    chk({tag, ".id"},     64'(bus.oseq_id), 64'(id));
    chk({tag, ".mag"},    64'(bus.opeak_mag), 64'(mag));
    chk({tag, ".ts"},     64'(bus.otimestamp), 64'(ts));
  endtask

  initial begin
    bus.erx_en = 1'b1;
    bus.icorr_valid = 1'b0;
    bus.icorr_seq = '0;
    bus.ithreshold = '0;

    // Peak rising then decaying on seq5; hold-off swallows an early peak.
    b_thr = 150;
    put(5, 100, 0, 0, 0, 0); put(5, 200, 0, 0, 0, 0); put(5, 300, 0, 0, 0, 0);
    put(5, 250, 0, 0, 0, 0); put(5, 240, 0, 0, 0, 0); put(5, 230, 0, 0, 0, 0);
    putd(5, 220, 5, 300, 2);                         // ts 6
    zeros(2); put(2, 900, 0, 0, 0, 0);               // ts 9, inside hold-off
    zeros(8); put(2, 900, 0, 0, 0, 0);               // ts 18, searching again
    zeros(3); putd(0, 0, 2, 900, 18);                // ts 22
    // Negative magnitude wins; then tie between seq3 and seq12.
    b_flush = 1'b1; b_thr = 100;
    put(9, -1000, 3, 500, 12, 500);                  // ts 0
    zeros(3); putd(0, 0, 9, 1000, 0);
    zeros(8); put(3, 500, 12, 500, 0, 0);            // ts 13
    zeros(3); putd(0, 0, 3, 500, 13);
    // Magnitude equal to threshold never triggers; most negative input.
    b_flush = 1'b1; b_thr = 1000;
    for (int i = 0; i < 6; i++) put(0, 1000, 8, -1000, 0, 0);
    put(4, -(64'sd1 <<< 40), 0, 0, 0, 0);            // ts 6
    zeros(3); putd(0, 0, 4, 64'sd1 <<< 40, 6);

    repeat (3) @(posedge clk);
    #1;
    chk("reset.detect",  64'(bus.odetect), 64'd0);
    chk("reset.id",      64'(bus.oseq_id), 64'd0);
    chk("reset.mag",     64'(bus.opeak_mag), 64'd0);
    chk("reset.ts",      64'(bus.otimestamp), 64'd0);
    chk("reset.overrun", 64'(bus.ooverrun), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[k]) begin
      if (tbl[k].flush) flush();
      apply(tbl[k].ia, tbl[k].va, tbl[k].ib, tbl[k].vb, tbl[k].ic, tbl[k].vc, tbl[k].thr);
      chk_out($sformatf("vec%0d", k), tbl[k].det, tbl[k].id, tbl[k].mag, tbl[k].ts);
    end

    // Overrun: second valid 10 clocks after the first is dropped but counted.
    flush();
    chk("ovr.clear", 64'(bus.ooverrun), 64'd0);
    @(negedge clk);
    bus.ithreshold = CORR_W'(100);
    bus.icorr_seq = '0;
    bus.icorr_valid = 1'b1;
    @(posedge clk);
    #1 bus.icorr_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1 bus.icorr_valid = 1'b1;
    @(posedge clk);
    #1 bus.icorr_valid = 1'b0;
    chk("ovr.set", 64'(bus.ooverrun), 64'd1);
    repeat (8) @(posedge clk);
    apply(7, 5000, 0, 0, 0, 0, 100);                 // ts 2
    for (int i = 0; i < 3; i++) apply(0, 0, 0, 0, 0, 0, 100);
    apply(0, 0, 0, 0, 0, 0, 100);
    chk_out("ovr", 1'b1, 7, 5000, 2);

    // Enable low while tracking discards the candidate.
    flush();
    apply(1, 4000, 0, 0, 0, 0, 100);
    apply(0, 0, 0, 0, 0, 0, 100);
    apply(0, 0, 0, 0, 0, 0, 100);
    flush();
    for (int i = 0; i < 4; i++) begin
      apply(0, 0, 0, 0, 0, 0, 100);
      chk("flush.nodet", 64'(bus.odetect), 64'd0);
    end
    chk_out("flush.held", 1'b0, 7, 5000, 2);
    chk("flush.ovr_sticky", 64'(bus.ooverrun), 64'd1);

    // Asynchronous reset mid-TRACK.
    apply(1, 3000, 0, 0, 0, 0, 100);
    apply(0, 0, 0, 0, 0, 0, 100);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_out("rst_async", 1'b0, 0, 0, 0);
    chk("rst_async.overrun", 64'(bus.ooverrun), 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    apply(6, 700, 0, 0, 0, 0, 100);                  // ts 0 after reset
    for (int i = 0; i < 3; i++) apply(0, 0, 0, 0, 0, 0, 100);
    apply(0, 0, 0, 0, 0, 0, 100);
    chk_out("post_rst", 1'b1, 6, 700, 0);

    repeat (3) @(posedge clk);
    #1 chk("total_detects", 64'(det_cnt), 64'd7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
